// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment pattern constants, segment bit indices and capture FSM states
package seg7_pkg;
   localparam logic [6:0] SEG7_0 = 7'h3F;
   localparam logic [6:0] SEG7_1 = 7'h06;
   localparam logic [6:0] SEG7_2 = 7'h5B;
   localparam logic [6:0] SEG7_3 = 7'h4F;
   localparam logic [6:0] SEG7_4 = 7'h66;
   localparam logic [6:0] SEG7_5 = 7'h6D;
   localparam logic [6:0] SEG7_6 = 7'h7D;
   localparam logic [6:0] SEG7_7 = 7'h07;
   localparam logic [6:0] SEG7_8 = 7'h7F;
   localparam logic [6:0] SEG7_9 = 7'h6F;
   localparam logic [6:0] SEG7_A = 7'h77;
   localparam logic [6:0] SEG7_B = 7'h7C;
   localparam logic [6:0] SEG7_C = 7'h39;
   localparam logic [6:0] SEG7_D = 7'h5E;
   localparam logic [6:0] SEG7_E = 7'h79;
   localparam logic [6:0] SEG7_F = 7'h71;
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam logic [6:0] SEG7_TABLE [16] = '{SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5, SEG7_6, SEG7_7,
                                             SEG7_8, SEG7_9, SEG7_A, SEG7_B, SEG7_C, SEG7_D, SEG7_E, SEG7_F};
   typedef enum logic {ACQUIRE, COMPARE} frame_state_e;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-high gfedcba pattern to digit; SEVEN_SEG_CAPTURE_HEX_EN adds A-F
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       valid,
   output logic [3:0] digit
);
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
   localparam int N = 16;
`else
   localparam int N = 10;
`endif
   always_comb begin
      valid = 1'b0;
      digit = 4'h0;
      for (int i = 0; i < N; i++)
         if (pattern == SEG7_TABLE[i]) begin
            valid = 1'b1;
            digit = 4'(i);
         end
   end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a scanned 7-seg display and commits stable 4-digit BCD frames
// Optional macro SEVEN_SEG_CAPTURE_HEX_EN (via seg7_pattern_decode) accepts hex digits A-F.
module seven_seg_capture
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int FRAMES_STABLE  = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic        dp_in,
   input  logic [3:0]  an_in,
   output logic [15:0] bcd,
   output logic [3:0]  dp_out,
   output logic        update,
   output logic        frame_err,
   output logic        locked
);
   localparam logic [11:0] POL = {{4{AN_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};
   localparam logic [3:0]  FS  = 4'(FRAMES_STABLE);
   frame_state_e state, n_state;
   logic [11:0] s1, s2, s3;
   logic [7:0]  cnt;
   logic [3:0]  an_h, mask, n_mask, dp_w, n_dp_w, dp_c, n_dp_c, n_dp, match, n_match;
   logic [15:0] bcd_w, n_bcd_w, bcd_c, n_bcd_c, n_bcd;
   logic [6:0]  seg_h;
   logic [3:0]  dec_digit;
   logic [1:0]  idx;
   logic        dp_h, dec_valid, sample, blank, multi, good, bad, n_update, n_err, n_locked;
   // polarity is flipped before the first flop so reset-zero means idle
   assign {an_h, dp_h, seg_h} = s3;
   assign sample = cnt == 8'(SETTLE_CYCLES - 1);
   assign blank  = an_h == 4'h0;
   assign multi  = (an_h & (an_h - 4'd1)) != 4'h0;
   assign good   = sample && !blank && !multi && dec_valid;
   assign bad    = sample && !blank && (multi || !dec_valid);
   assign idx    = an_h[3] ? 2'd3 : an_h[2] ? 2'd2 : an_h[1] ? 2'd1 : 2'd0;
   seg7_pattern_decode u_dec (.pattern(seg_h), .valid(dec_valid), .digit(dec_digit));
   always_comb begin
      n_state  = state;
      n_mask   = mask;
      n_bcd_w  = bcd_w;
      n_dp_w   = dp_w;
      n_bcd_c  = bcd_c;
      n_dp_c   = dp_c;
      n_match  = match;
      n_bcd    = bcd;
      n_dp     = dp_out;
      n_locked = locked;
      n_update = 1'b0;
      n_err    = 1'b0;
      if (state == COMPARE) begin
         n_mask  = 4'h0;
         n_state = ACQUIRE;
         if ({bcd_w, dp_w} == {bcd_c, dp_c})
            n_match = match == FS ? match : match + 4'd1;
         else begin
            n_bcd_c = bcd_w;
            n_dp_c  = dp_w;
            n_match = 4'd1;
         end
         if (n_match == FS && ({n_bcd_c, n_dp_c} != {bcd, dp_out} || !locked)) begin
            n_bcd    = n_bcd_c;
            n_dp     = n_dp_c;
            n_locked = 1'b1;
            n_update = 1'b1;
         end
      end else if (mask == 4'hF)
         n_state = COMPARE;
      // a sample landing on the COMPARE cycle goes into the freshly cleared mask
      if (good) begin
         n_mask[idx]             = 1'b1;
         n_bcd_w[{idx, 2'b00} +: 4] = dec_digit;
         n_dp_w[idx]             = dp_h;
      end
      if (bad) begin
         n_err    = 1'b1;
         n_mask   = 4'h0;
         n_match  = 4'd0;
         n_locked = 1'b0;
         n_update = 1'b0;
         n_bcd    = bcd;
         n_dp     = dp_out;
         n_state  = ACQUIRE;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1        <= 12'h0;
         s2        <= 12'h0;
         s3        <= 12'h0;
         cnt       <= 8'd0;
         state     <= ACQUIRE;
         mask      <= 4'h0;
         bcd_w     <= 16'h0;
         dp_w      <= 4'h0;
         bcd_c     <= 16'h0;
         dp_c      <= 4'h0;
         match     <= 4'd0;
         bcd       <= 16'h0;
         dp_out    <= 4'h0;
         locked    <= 1'b0;
         update    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s1        <= {an_in, dp_in, seg_in} ^ POL;
         s2        <= s1;
         s3        <= s2;
         cnt       <= s2 != s3 ? 8'd0 : cnt == 8'(SETTLE_CYCLES) ? cnt : cnt + 8'd1;
         state     <= n_state;
         mask      <= n_mask;
         bcd_w     <= n_bcd_w;
         dp_w      <= n_dp_w;
         bcd_c     <= n_bcd_c;
         dp_c      <= n_dp_c;
         match     <= n_match;
         bcd       <= n_bcd;
         dp_out    <= n_dp;
         locked    <= n_locked;
         update    <= n_update;
         frame_err <= n_err;
      end
endmodule
